// File: rtl/roi_frame_responder.sv
// rtl/roi_frame_responder.sv - streams a requested ROI window from frame memory as pixel/de/vsync
// Optional ROI_TEST_PATTERN_EN: replaces memory data with an {x,y,A5} pattern and holds mem_rd low.
module roi_frame_responder #(
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int VSYNC_CYCLES = 4,
  parameter int LINE_GAP     = 2,
  parameter int ADDR_W       = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ARMImgRequest,
  input  logic [10:0]       HorMinIn,
  input  logic [10:0]       HorMaxIn,
  input  logic [8:0]        VerMinIn,
  input  logic [8:0]        VerMaxIn,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [23:0]       mem_data,
  output logic [23:0]       pixel_out,
  output logic              de_out,
  output logic              vsync_out,
  output logic              busy,
  output logic              frame_done,
  output logic              req_err
);

  typedef enum logic [2:0] {S_IDLE, S_LATCH, S_VSYNC, S_ROW, S_GAP, S_DONE} state_t;

  localparam logic [10:0] LP_HMAX = 11'(FRAME_WIDTH - 1);
  localparam logic [8:0]  LP_VMAX = 9'(FRAME_HEIGHT - 1);

  state_t            r_state;
  logic              r_req_d;
  logic [10:0]       r_hmin, r_hmax, r_x;
  logic [8:0]        r_vmin, r_vmax, r_y;
  logic [ADDR_W-1:0] r_row_base, r_addr;
  logic [15:0]       r_cnt;
  logic              r_rd, r_de, r_vsync, r_busy, r_done, r_err;
  logic [23:0]       r_pix;

  logic              w_edge;
  logic [10:0]       w_hmax_c, w_x_next;
  logic [8:0]        w_vmax_c;

  assign w_edge   = ARMImgRequest & ~r_req_d;
  assign w_hmax_c = (r_hmax > LP_HMAX) ? LP_HMAX : r_hmax;
  assign w_vmax_c = (r_vmax > LP_VMAX) ? LP_VMAX : r_vmax;
  assign w_x_next = r_x + 11'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_req_d    <= 1'b0;
      r_hmin     <= '0;
      r_hmax     <= '0;
      r_vmin     <= '0;
      r_vmax     <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_row_base <= '0;
      r_addr     <= '0;
      r_cnt      <= '0;
      r_rd       <= 1'b0;
      r_de       <= 1'b0;
      r_vsync    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_pix      <= '0;
    end else begin
      r_req_d <= ARMImgRequest;
      r_de    <= r_rd;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      // Pattern pixel is captured from the coordinates of the read cycle so it lines up with de
      r_pix   <= r_rd ? {r_x[7:0], r_y[7:0], 8'hA5} : 24'h0;
      case (r_state)
        S_IDLE: begin
          if (w_edge) begin
            r_hmin  <= HorMinIn;
            r_hmax  <= HorMaxIn;
            r_vmin  <= VerMinIn;
            r_vmax  <= VerMaxIn;
            r_state <= S_LATCH;
          end
        end
        S_LATCH: begin
          if ((r_hmin > w_hmax_c) || (r_vmin > w_vmax_c)) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_hmax     <= w_hmax_c;
            r_vmax     <= w_vmax_c;
            r_row_base <= ADDR_W'(r_vmin) * ADDR_W'(FRAME_WIDTH);
            r_y        <= r_vmin;
            r_busy     <= 1'b1;
            r_vsync    <= 1'b1;
            r_cnt      <= 16'(VSYNC_CYCLES - 1);
            r_state    <= S_VSYNC;
          end
        end
        S_VSYNC: begin
          if (r_cnt == 16'd0) begin
            r_vsync <= 1'b0;
            r_rd    <= 1'b1;
            r_x     <= r_hmin;
            r_addr  <= r_row_base + ADDR_W'(r_hmin);
            r_state <= S_ROW;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        S_ROW: begin
          if (r_x == r_hmax) begin
            r_rd <= 1'b0;
            if (r_y < r_vmax) begin
              // Row base advances by one line; no per-pixel multiply
              r_row_base <= r_row_base + ADDR_W'(FRAME_WIDTH);
              r_y        <= r_y + 9'd1;
              r_cnt      <= 16'(LINE_GAP - 1);
              r_state    <= S_GAP;
            end else begin
              r_state <= S_DONE;
            end
          end else begin
            r_x    <= w_x_next;
            r_addr <= r_row_base + ADDR_W'(w_x_next);
          end
        end
        S_GAP: begin
          if (r_cnt == 16'd0) begin
            r_rd    <= 1'b1;
            r_x     <= r_hmin;
            r_addr  <= r_row_base + ADDR_W'(r_hmin);
            r_state <= S_ROW;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_addr   = r_addr;
  assign de_out     = r_de;
  assign vsync_out  = r_vsync;
  assign busy       = r_busy;
  assign frame_done = r_done;
  assign req_err    = r_err;

`ifdef ROI_TEST_PATTERN_EN
  assign mem_rd    = 1'b0;
  assign pixel_out = r_pix;
`else
  // Memory returns data one cycle after the strobe, the same cycle de_out rises
  assign mem_rd    = r_rd;
  assign pixel_out = r_de ? mem_data : 24'h0;
`endif

endmodule

// File: tb/tb_roi_frame_responder.sv
// tb/tb_roi_frame_responder.sv - scoreboard bench for roi_frame_responder
module tb_roi_frame_responder;
  localparam int LINE_GAP = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ARMImgRequest = 1'b0;
  logic [10:0] HorMinIn = '0, HorMaxIn = '0;
  logic [8:0]  VerMinIn = '0, VerMaxIn = '0;
  logic        mem_rd;
  logic [18:0] mem_addr;
  logic [23:0] mem_data = '0;
  logic [23:0] pixel_out;
  logic        de_out, vsync_out, busy, frame_done, req_err;

  roi_frame_responder dut (
    .clk(clk), .rst(rst), .ARMImgRequest(ARMImgRequest),
    .HorMinIn(HorMinIn), .HorMaxIn(HorMaxIn), .VerMinIn(VerMinIn), .VerMaxIn(VerMaxIn),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
    .pixel_out(pixel_out), .de_out(de_out), .vsync_out(vsync_out),
    .busy(busy), .frame_done(frame_done), .req_err(req_err)
  );

  always #5 clk = ~clk;

  // Memory model: each word holds its own address
  always @(posedge clk) if (mem_rd) mem_data <= 24'(mem_addr);

  int errors = 0;
  int checks = 0;
  logic [23:0] exp_q[$];
  int first_vs, last_vs, vs_count, first_de, de_count, done_cycle, err_cycle;
  int busy_seen, rd_seen, line_bad, gap_bad;
  logic [23:0] last_pix;

  task automatic push_window(input int hmin, input int hmax, input int vmin, input int vmax);
    for (int y = vmin; y <= vmax; y++)
      for (int x = hmin; x <= hmax; x++)
        exp_q.push_back(24'(y * 640 + x));
  endtask

  task automatic start_req(input int hmin, input int hmax, input int vmin, input int vmax);
    @(posedge clk); #1;
    ARMImgRequest = 1'b0;
    HorMinIn = 11'(hmin); HorMaxIn = 11'(hmax);
    VerMinIn = 9'(vmin);  VerMaxIn = 9'(vmax);
    @(posedge clk); #1;
    ARMImgRequest = 1'b1;
  endtask

  task automatic run_frame(input int budget, input int exp_w, input int poke);
    int run_len, low_len, stop_at;
    bit had_de, prev_de;
    logic [23:0] exp;
    first_vs = -1; last_vs = -1; vs_count = 0; first_de = -1; de_count = 0;
    done_cycle = -1; err_cycle = -1; busy_seen = 0; rd_seen = 0; line_bad = 0; gap_bad = 0;
    last_pix = '0; run_len = 0; low_len = 0; had_de = 0; prev_de = 0; stop_at = budget;
    for (int k = 1; k <= budget && k <= stop_at; k++) begin
      @(posedge clk); #1;
      if (k == poke) ARMImgRequest = 1'b0;
      if (k == poke + 1) begin
        ARMImgRequest = 1'b1;
        HorMinIn = 11'd0; HorMaxIn = 11'd2047; VerMinIn = 9'd0; VerMaxIn = 9'd511;
      end
      if (vsync_out) begin
        if (first_vs < 0) first_vs = k;
        last_vs = k;
        vs_count++;
      end
      if (busy) busy_seen = 1;
      if (mem_rd) rd_seen = 1;
      if (de_out) begin
        if (first_de < 0) first_de = k;
        de_count++;
        if (had_de && !prev_de && low_len != LINE_GAP) gap_bad++;
        run_len++; low_len = 0; had_de = 1;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pixel_extra cycle %0d got %h expected none", k, pixel_out);
        end else begin
          exp = exp_q.pop_front();
          if (pixel_out !== exp) begin
            errors++;
            $display("FAIL pixel cycle %0d got %h expected %h", k, pixel_out, exp);
          end
        end
        last_pix = pixel_out;
      end else begin
        if (prev_de && run_len != exp_w) line_bad++;
        if (prev_de) run_len = 0;
        low_len++;
      end
      prev_de = de_out;
      if (frame_done && done_cycle < 0) begin done_cycle = k; stop_at = k + 2; end
      if (req_err && err_cycle < 0) begin err_cycle = k; stop_at = k + 4; end
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if ({mem_rd, de_out, vsync_out, busy, frame_done, req_err} !== 6'b0 || pixel_out !== 24'h0) begin
      errors++;
      $display("FAIL %s got ctl=%b pixel=%h expected all zero", name,
               {mem_rd, de_out, vsync_out, busy, frame_done, req_err}, pixel_out);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset_outputs");
    checks++;
    if (mem_addr !== 19'd0) begin
      errors++;
      $display("FAIL reset_addr got %0d expected 0", mem_addr);
    end
    rst = 1'b0;
  endtask

  task automatic test_roi_basic;
    exp_q.delete();
    push_window(10, 13, 20, 21);
    start_req(10, 13, 20, 21);
    run_frame(200, 4, -1);
    check_int("basic_de_count", de_count, 8);
    check_int("basic_left", exp_q.size(), 0);
    check_int("basic_done_seen", int'(done_cycle > 0), 1);
    check_int("basic_line_len", line_bad, 0);
    check_int("basic_gap_len", gap_bad, 0);
    check_int("basic_busy_seen", busy_seen, 1);
    check_int("basic_busy_after", int'(busy), 0);
  endtask

  task automatic test_latency;
    exp_q.delete();
    push_window(0, 1, 0, 0);
    start_req(0, 1, 0, 0);
    run_frame(100, 2, -1);
    check_int("lat_first_vs", first_vs, 2);
    check_int("lat_last_vs", last_vs, 5);
    check_int("lat_vs_count", vs_count, 4);
    check_int("lat_first_de", first_de, 7);
    check_int("lat_de_count", de_count, 2);
  endtask

  task automatic test_clamp;
    exp_q.delete();
    push_window(636, 639, 478, 479);
    start_req(636, 2000, 478, 500);
    run_frame(200, 4, -1);
    check_int("clamp_de_count", de_count, 8);
    check_int("clamp_last_addr", int'(last_pix), 307199);
    check_int("clamp_left", exp_q.size(), 0);
    check_int("clamp_done_seen", int'(done_cycle > 0), 1);
  endtask

  task automatic test_empty;
    exp_q.delete();
    start_req(50, 40, 0, 0);
    run_frame(30, 1, -1);
    check_int("empty_err_cycle", err_cycle, 2);
    check_int("empty_vs_count", vs_count, 0);
    check_int("empty_de_count", de_count, 0);
    check_int("empty_busy_seen", busy_seen, 0);
    check_int("empty_no_done", done_cycle, -1);
  endtask

  task automatic test_ignore_busy;
    exp_q.delete();
    push_window(0, 3, 0, 1);
    start_req(0, 3, 0, 1);
    run_frame(200, 4, 8);
    check_int("ignore_de_count", de_count, 8);
    check_int("ignore_left", exp_q.size(), 0);
    check_int("ignore_done_seen", int'(done_cycle > 0), 1);
    check_int("ignore_line_len", line_bad, 0);
  endtask

  task automatic test_reset_abort;
    exp_q.delete();
    push_window(0, 7, 0, 0);
    start_req(0, 7, 0, 0);
    run_frame(9, 8, -1);
    check_int("abort_pre_de", de_count, 3);
    rst = 1'b1;
    ARMImgRequest = 1'b0;
    @(posedge clk); #1;
    check_idle_outputs("abort_outputs");
    rst = 1'b0;
    exp_q.delete();
    push_window(0, 7, 0, 0);
    start_req(0, 7, 0, 0);
    run_frame(200, 8, -1);
    check_int("abort_refill_de", de_count, 8);
    check_int("abort_refill_vs", vs_count, 4);
    check_int("abort_refill_done", int'(done_cycle > 0), 1);
    check_int("abort_refill_left", exp_q.size(), 0);
  endtask

`ifdef ROI_TEST_PATTERN_EN
  task automatic test_pattern;
    exp_q.delete();
    exp_q.push_back(24'h0507A5);
    start_req(5, 5, 7, 7);
    run_frame(100, 1, -1);
    check_int("pattern_de_count", de_count, 1);
    check_int("pattern_rd_seen", rd_seen, 0);
    check_int("pattern_left", exp_q.size(), 0);
  endtask
`endif

  initial begin
    test_reset();
    test_roi_basic();
    test_latency();
    test_clamp();
    test_empty();
    test_ignore_busy();
    test_reset_abort();
`ifdef ROI_TEST_PATTERN_EN
    test_pattern();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
